// File: rtl/bram_rw_ctrl_multi.sv
// rtl/bram_rw_ctrl_multi.sv - multi-lane BRAM capture buffer with one-shot or looping readback
module bram_rw_ctrl_multi #(
  parameter int DATA_W = 12,
  parameter int LANES  = 2,
  parameter int DEPTH  = 10000,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      play_start,
  input  logic                      play_stop,
  input  logic                      loop_en,
  input  logic                      clear,
  output logic                      ram_en,
  output logic                      ram_we,
  output logic [LANES*ADDR_W-1:0]   ram_addr,
  output logic [LANES*DATA_W-1:0]   ram_wr_data,
  output logic                      wr_done,
  output logic                      rd_valid,
  output logic                      overflow,
  output logic [1:0]                state
);

  localparam int SEG = DEPTH / LANES;
  localparam logic [ADDR_W-1:0] SEG_LAST = ADDR_W'(SEG - 1);
  localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(DEPTH - LANES);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    PLAY = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd, drop;
  logic [RD_LAT-1:0] rd_pipe;

  assign state    = state_q;
  assign rd_valid = rd_pipe[RD_LAT-1];

  always_comb begin
    state_d = state_q;
    do_wr   = 1'b0;
    do_rd   = 1'b0;
    drop    = 1'b0;
    if (clear) begin
      state_d = FILL;
    end else begin
      case (state_q)
        IDLE: state_d = FILL;
        FILL: begin
          if (in_valid) begin
            do_wr = 1'b1;
            if (wr_ptr == WR_LAST) state_d = FULL;
          end
        end
        FULL: begin
          drop = in_valid;
          if (play_start) state_d = PLAY;
        end
        PLAY: begin
          drop = in_valid;
          // stop wins over the end-of-segment wrap
          if (play_stop) begin
            state_d = FULL;
          end else begin
            do_rd = 1'b1;
            if (rd_ptr == SEG_LAST && !loop_en) state_d = FULL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_en      <= 1'b0;
      ram_we      <= 1'b1;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      wr_done     <= 1'b0;
      overflow    <= 1'b0;
      rd_pipe     <= '0;
    end else begin
      state_q <= state_d;
      ram_en  <= do_wr | do_rd;
      rd_pipe <= RD_LAT'({rd_pipe, ram_en & ~ram_we});
      if (do_wr | do_rd) ram_we <= do_wr;
      if (do_wr) begin
        ram_wr_data <= in_data;
        wr_ptr      <= wr_ptr + STEP;
      end
      // lane k reads segment k, so each lane walks its own contiguous slice
      for (int k = 0; k < LANES; k++) begin
        if (do_wr)
          ram_addr[k*ADDR_W +: ADDR_W] <= wr_ptr + ADDR_W'(k);
        else if (do_rd)
          ram_addr[k*ADDR_W +: ADDR_W] <= ADDR_W'(k * SEG) + rd_ptr;
      end
      if (do_rd) rd_ptr <= (rd_ptr == SEG_LAST) ? '0 : rd_ptr + 1'b1;
      if (state_q == FULL && state_d == PLAY) rd_ptr <= '0;
      if (state_q == FULL) wr_done <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        wr_done  <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bram_rw_ctrl_multi.md
BRAM_RW_CTRL_MULTI -- requirements
Module: bram_rw_ctrl_multi

Interface
REQ-001 SHALL provide parameter DATA_W, default 12, sample width.
REQ-002 SHALL provide parameter LANES, default 2, samples per beat and number of BRAM ports; legal values 1, 2, 4.
REQ-003 SHALL provide parameter DEPTH, default 10000, total samples stored; must be a multiple of LANES.
REQ-004 SHALL provide parameter ADDR_W, default 15, BRAM address width; 2^ADDR_W >= DEPTH.
REQ-005 SHALL provide parameter RD_LAT, default 2, BRAM read latency in cycles (1..4).
REQ-006 SHALL have clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have in_valid, input, 1, one beat of LANES samples is present.
REQ-009 SHALL have in_data, input, LANES*DATA_W, lane k at bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have play_start, input, 1, single-cycle request to begin readback.
REQ-011 SHALL have play_stop, input, 1, single-cycle request to end readback.
REQ-012 SHALL have loop_en, input, 1, 1 = continuous readback, 0 = one pass.
REQ-013 SHALL have clear, input, 1, single-cycle request to discard the buffer and refill.
REQ-014 SHALL have ram_en, ram_we, output, 1 each; ram_addr, output, LANES*ADDR_W; ram_wr_data, output, LANES*DATA_W.
REQ-015 SHALL have wr_done, output, 1, buffer full; rd_valid, output, 1, ram read data valid on the BRAM output this cycle; overflow, output, 1, sticky dropped-beat flag; state, output, 2, current FSM state.

Function
REQ-016 SHALL implement FSM IDLE=0, FILL=1, FULL=2, PLAY=3; it leaves reset in FILL.
REQ-017 In FILL, each in_valid beat SHALL write on the next cycle: ram_en=1, ram_we=1, lane k addr = wr_ptr+k, lane k data = in_data lane k; wr_ptr then advances by LANES.
REQ-018 When wr_ptr reaches DEPTH, the FSM SHALL enter FULL, and wr_done SHALL go high on the cycle after the last write and stay high until clear or rst.
REQ-019 When in_valid is 0 in FILL, ram_en SHALL be 0 and addr/data SHALL hold their previous values.
REQ-020 An in_valid beat in FULL or PLAY SHALL be dropped (no write) and SHALL set overflow; overflow clears only on clear or rst.
REQ-021 play_start in FULL SHALL enter PLAY; in IDLE, FILL or PLAY it SHALL be ignored.
REQ-022 In PLAY, every cycle SHALL issue a read: ram_en=1, ram_we=0, lane k addr = k*(DEPTH/LANES) + rd_ptr; rd_ptr counts 0..DEPTH/LANES-1, starting at 0 on PLAY entry.
REQ-023 At rd_ptr = DEPTH/LANES-1: with loop_en=1, rd_ptr SHALL wrap to 0 with no gap cycle; with loop_en=0, the FSM SHALL return to FULL after that read. loop_en is sampled at the wrap cycle.
REQ-024 play_stop in PLAY SHALL return the FSM to FULL the next cycle, with no read issued in that cycle; play_stop takes priority over the wrap.
REQ-025 rd_valid SHALL equal ram_en&~ram_we delayed by exactly RD_LAT cycles through a shift register; in-flight reads still complete after stop.
REQ-026 clear in any state SHALL reset wr_ptr, rd_ptr, wr_done and overflow, and enter FILL next cycle; clear overrides play_start, play_stop and in_valid in the same cycle, and that beat is dropped without setting overflow.
REQ-027 IDLE SHALL be reachable only as a recovery for an illegal state encoding; from IDLE the FSM goes to FILL next cycle.
REQ-028 Pointer widths SHALL be ADDR_W bits; all address sums SHALL stay below DEPTH without truncation.

Reset
REQ-029 While rst=1, the block SHALL drive: state=FILL, ram_en=0, ram_we=1, ram_addr=0 for all lanes, ram_wr_data=0, wr_done=0, rd_valid=0, overflow=0, both pointers 0, and the rd_valid pipe cleared.
REQ-030 rst asserted mid-FILL or mid-PLAY SHALL abandon the operation with no further BRAM access; the first write after release goes to address 0.

Verification (LANES=2, DEPTH=8, RD_LAT=2 unless stated)
REQ-031 Four consecutive beats (1,2), (3,4), (5,6), (7,8) -> write addrs (0,1), (2,3), (4,5), (6,7) with matching data; wr_done=1 on the cycle after the 4th write; state=FULL.
REQ-032 After fill, play_start with loop_en=0 -> reads (0,4), (1,5), (2,6), (3,7) on 4 consecutive cycles; rd_valid high for 4 cycles starting 2 cycles after the first read; then state=FULL.
REQ-033 loop_en=1, 10 cycles in PLAY -> address sequence 0,1,2,3,0,1,2,3,0,1 on lane 0 with no gap; play_stop -> no read the next cycle; rd_valid drains after 2 cycles.
REQ-034 in_valid while FULL -> no write, overflow=1; clear in the same cycle as in_valid -> overflow=0, state=FILL, next beat written to (0,1).
REQ-035 rst pulse during PLAY at rd_ptr=2 -> all REQ-029 values hold the next cycle; a refill starts at address 0.
REQ-036 LANES=4, DEPTH=16 -> write addrs step by 4; play reads lanes at offsets 0, 4, 8, 12.
